// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM states, mode selectors and maximal-length tap masks
package lfsr_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} fsm_e;
    localparam int MODE_FIB = 0;
    localparam int MODE_GAL = 1;
    localparam logic [3:0]  TAPS_4  = 4'b1001;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;
endpackage

// File: rtl/lfsr_gen_next.sv
// lfsr_next: combinational single LFSR step, Fibonacci or Galois
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_16,
    parameter int               MODE  = MODE_FIB
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] next_o
);
    // Galois folds taps in on a shifted-out one; Fibonacci shifts in the tap parity
    always_comb next_o = (MODE == MODE_GAL) ? ((state_i >> 1) ^ (state_i[0] ? TAPS : '0))
                                            : {state_i[WIDTH-2:0], ^(state_i & TAPS)};
endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: LFSR with free-running and counted burst stepping, seed load and lockup guard
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_16,
    parameter int               MODE  = MODE_FIB,
    parameter logic [WIDTH-1:0] SEED  = 1,
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             enable,
    input  logic             start,
    input  logic [CNT_W-1:0] n_steps,
    output logic [WIDTH-1:0] state_out,
    output logic             bit_out,
    output logic             busy,
    output logic             done,
    output logic             lockup
);
    fsm_e             fsm_q;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] step_val;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic             lockup_q;
    logic             step;

    lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS), .MODE(MODE)) u_next (
        .state_i (state_q),
        .next_o  (step_val)
    );

    // Load beats stepping; any all-zero candidate is replaced by SEED so the register never locks up
    always_comb begin
        step    = (fsm_q == ST_RUN) || ((fsm_q == ST_IDLE) && enable && !start);
        state_d = load ? ((seed_in == '0) ? SEED : seed_in)
                : step ? ((step_val == '0) ? SEED : step_val)
                : state_q;
    end

    // Control FSM: counted burst with registered done and lockup pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= ST_IDLE;
            state_q  <= SEED;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lockup_q <= load && (seed_in == '0);
            done_q   <= 1'b0;
            case (fsm_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_q  <= n_steps;
                        fsm_q  <= (n_steps == '0) ? ST_DONE : ST_RUN;
                        done_q <= (n_steps == '0);
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        fsm_q  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign state_out = state_q;
    assign bit_out   = state_q[0];
    assign busy      = (fsm_q == ST_RUN);
    assign done      = done_q;
    assign lockup    = lockup_q;
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: scoreboard bench for Fibonacci and Galois LFSR instances
module tb_lfsr_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, load = 1'b0, enable = 1'b0, start = 1'b0;
    logic [3:0]  seed_in = 4'd0;
    logic [15:0] n_steps = 16'd0;
    logic        rst_b = 1'b1, en_b = 1'b0;
    logic        tie1 = 1'b0;
    logic [3:0]  tie4 = 4'd0;
    logic [15:0] tie16 = 16'd0;
    logic [3:0]  state_a, state_b;
    logic        bit_a, busy_a, done_a, lock_a;
    logic        bit_b, busy_b, done_b, lock_b;

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1001), .MODE(0), .SEED(4'd1), .CNT_W(16)) dut_fib (
        .clk(clk), .rst(rst), .load(load), .seed_in(seed_in), .enable(enable),
        .start(start), .n_steps(n_steps), .state_out(state_a), .bit_out(bit_a),
        .busy(busy_a), .done(done_a), .lockup(lock_a)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .MODE(1), .SEED(4'd1), .CNT_W(16)) dut_gal (
        .clk(clk), .rst(rst_b), .load(tie1), .seed_in(tie4), .enable(en_b),
        .start(tie1), .n_steps(tie16), .state_out(state_b), .bit_out(bit_b),
        .busy(busy_b), .done(done_b), .lockup(lock_b)
    );

    typedef struct {
        logic [3:0] sa;
        logic       busy;
        logic       done;
        logic       lock;
        logic       chkb;
        logic [3:0] sb;
        int         id;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    int         tag = 0;
    logic [3:0] ma = 4'd1;
    logic [3:0] mb = 4'd1;

    function automatic logic [3:0] fib4(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[0]};
    endfunction

    function automatic logic [3:0] gal4(input logic [3:0] s);
        return (s >> 1) ^ (s[0] ? 4'b1100 : 4'b0000);
    endfunction

    task automatic drive(input logic ld, input logic [3:0] sd, input logic en, input logic st,
                         input logic [15:0] n, input logic rs, input logic eb, input logic rb);
        @(negedge clk);
        load = ld;
        seed_in = sd;
        enable = en;
        start = st;
        n_steps = n;
        rst = rs;
        en_b = eb;
        rst_b = rb;
    endtask

    task automatic expect_out(input logic [3:0] sa, input logic bs, input logic dn, input logic lk,
                              input logic cb, input logic [3:0] sb);
        exp_t e;
        e.sa = sa;
        e.busy = bs;
        e.done = dn;
        e.lock = lk;
        e.chkb = cb;
        e.sb = sb;
        e.id = tag;
        tag++;
        sbq.push_back(e);
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (state_a !== e.sa) begin errors++; $display("FAIL state_a #%0d got %b want %b", e.id, state_a, e.sa); end
            checks++;
            if (bit_a !== e.sa[0]) begin errors++; $display("FAIL bit_out #%0d got %b want %b", e.id, bit_a, e.sa[0]); end
            checks++;
            if (busy_a !== e.busy) begin errors++; $display("FAIL busy #%0d got %b want %b", e.id, busy_a, e.busy); end
            checks++;
            if (done_a !== e.done) begin errors++; $display("FAIL done #%0d got %b want %b", e.id, done_a, e.done); end
            checks++;
            if (lock_a !== e.lock) begin errors++; $display("FAIL lockup #%0d got %b want %b", e.id, lock_a, e.lock); end
            if (e.chkb) begin
                checks++;
                if (state_b !== e.sb) begin errors++; $display("FAIL state_b #%0d got %b want %b", e.id, state_b, e.sb); end
            end
        end
    end

    task automatic test_reset();
        repeat (2) begin
            drive(0, 4'd0, 0, 0, 16'd0, 1, 0, 1);
            expect_out(4'd1, 0, 0, 0, 1, 4'd1);
        end
        ma = 4'd1;
        mb = 4'd1;
    endtask

    task automatic test_free_run();
        int seen_a[16];
        int seen_b[16];
        int period;
        period = 0;
        for (int v = 0; v < 16; v++) begin
            seen_a[v] = 0;
            seen_b[v] = 0;
        end
        for (int i = 1; i <= 15; i++) begin
            drive(0, 4'd0, 1, 0, 16'd0, 0, 1, 0);
            ma = fib4(ma);
            mb = gal4(mb);
            expect_out(ma, 0, 0, 0, 1, mb);
            @(posedge clk);
            #2;
            seen_a[state_a]++;
            seen_b[state_b]++;
            if (period == 0 && state_b == 4'd1) period = i;
        end
        for (int v = 1; v < 16; v++) begin
            checks++;
            if (seen_a[v] != 1) begin errors++; $display("FAIL fib_visit value %0d seen %0d want 1", v, seen_a[v]); end
            checks++;
            if (seen_b[v] != 1) begin errors++; $display("FAIL gal_visit value %0d seen %0d want 1", v, seen_b[v]); end
        end
        checks++;
        if (period != 15) begin errors++; $display("FAIL gal_period got %0d want 15", period); end
        drive(0, 4'd0, 0, 0, 16'd0, 0, 0, 0);
        expect_out(ma, 0, 0, 0, 1, mb);
    endtask

    task automatic test_burst();
        drive(0, 4'd0, 0, 1, 16'd5, 0, 0, 0);
        expect_out(ma, 1, 0, 0, 0, 4'd0);
        for (int i = 1; i <= 5; i++) begin
            drive(0, 4'd0, 1, 0, 16'd0, 0, 0, 0);
            ma = fib4(ma);
            expect_out(ma, i < 5, i == 5, 0, 0, 4'd0);
        end
        drive(0, 4'd0, 1, 1, 16'd3, 0, 0, 0);
        expect_out(ma, 0, 0, 0, 0, 4'd0);
        drive(0, 4'd0, 0, 0, 16'd0, 0, 0, 0);
        expect_out(ma, 0, 0, 0, 0, 4'd0);
    endtask

    task automatic test_zero_burst();
        drive(0, 4'd0, 0, 1, 16'd0, 0, 0, 0);
        expect_out(ma, 0, 1, 0, 0, 4'd0);
        drive(0, 4'd0, 0, 0, 16'd0, 0, 0, 0);
        expect_out(ma, 0, 0, 0, 0, 4'd0);
    endtask

    task automatic test_load();
        drive(1, 4'd0, 0, 0, 16'd0, 0, 0, 0);
        ma = 4'd1;
        expect_out(ma, 0, 0, 1, 0, 4'd0);
        drive(0, 4'd0, 0, 0, 16'd0, 0, 0, 0);
        expect_out(ma, 0, 0, 0, 0, 4'd0);
        drive(1, 4'b0110, 1, 0, 16'd0, 0, 0, 0);
        ma = 4'b0110;
        expect_out(ma, 0, 0, 0, 0, 4'd0);
        drive(0, 4'd0, 0, 1, 16'd5, 0, 0, 0);
        expect_out(ma, 1, 0, 0, 0, 4'd0);
        for (int i = 1; i <= 5; i++) begin
            if (i == 2) begin
                drive(1, 4'b1010, 0, 0, 16'd0, 0, 0, 0);
                ma = 4'b1010;
            end else begin
                drive(0, 4'd0, 0, 0, 16'd0, 0, 0, 0);
                ma = fib4(ma);
            end
            expect_out(ma, i < 5, i == 5, 0, 0, 4'd0);
        end
        drive(0, 4'd0, 0, 0, 16'd0, 0, 0, 0);
        expect_out(ma, 0, 0, 0, 0, 4'd0);
    endtask

    task automatic test_reset_mid();
        drive(0, 4'd0, 0, 1, 16'd10, 0, 0, 0);
        expect_out(ma, 1, 0, 0, 0, 4'd0);
        for (int i = 1; i <= 2; i++) begin
            drive(0, 4'd0, 0, 0, 16'd0, 0, 0, 0);
            ma = fib4(ma);
            expect_out(ma, 1, 0, 0, 0, 4'd0);
        end
        drive(1, 4'b0101, 1, 1, 16'd4, 1, 0, 0);
        ma = 4'd1;
        expect_out(ma, 0, 0, 0, 0, 4'd0);
        repeat (3) begin
            drive(0, 4'd0, 0, 0, 16'd0, 0, 0, 0);
            expect_out(ma, 0, 0, 0, 0, 4'd0);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_burst();
        test_zero_burst();
        test_load();
        test_reset_mid();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sbq.size() != 0) begin errors++; $display("FAIL drain pending %0d want 0", sbq.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 16: LFSR state width, legal range 3..64.
REQ-002 Parameter TAPS, default 16'hB400 (WIDTH bits): feedback polynomial mask; bit i set means state bit i participates.
REQ-003 Parameter MODE, default 0: 0 = Fibonacci, 1 = Galois.
REQ-004 Parameter SEED, default 1 (WIDTH bits, nonzero): reset and recovery state.
REQ-005 Parameter CNT_W, default 16: burst step-count width.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 load  input  1  load seed_in into state this cycle.
REQ-009 seed_in  input  WIDTH  value for load.
REQ-010 enable  input  1  free-running step request, honoured only in IDLE.
REQ-011 start  input  1  begin burst of n_steps steps, honoured only in IDLE.
REQ-012 n_steps  input  CNT_W  burst length, sampled on accepted start.
REQ-013 state_out  output  WIDTH  current LFSR state (registered).
REQ-014 bit_out  output  1  state_out[0], combinational from state register.
REQ-015 busy  output  1  high while FSM in RUN.
REQ-016 done  output  1  one-cycle pulse at burst completion.
REQ-017 lockup  output  1  one-cycle pulse when an all-zero load is rejected.

Function
REQ-018 Fibonacci step: fb = XOR of state bits selected by TAPS; next = {state[WIDTH-2:0], fb}.
REQ-019 Galois step: next = (state >> 1) XOR (state[0] ? TAPS : 0).
REQ-020 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-021 IDLE: start=1 with n_steps>0 -> RUN, remaining count = n_steps; start=1 with n_steps=0 -> DONE, no step; start has priority over enable.
REQ-022 IDLE with enable=1 and no start: one step per cycle, FSM stays IDLE.
REQ-023 RUN: exactly one step per cycle, count decrements; on the cycle performing the final step -> DONE.
REQ-024 DONE: done=1 for exactly one cycle, no step, -> IDLE unconditionally.
REQ-025 start and enable in RUN or DONE are ignored (no queueing).
REQ-026 load has priority over any step that cycle: state = seed_in, no step; in RUN the count still decrements, so the burst length is unchanged in cycles.
REQ-027 load with seed_in = 0: state = SEED instead, lockup=1 next cycle.
REQ-028 busy = (FSM == RUN); done and lockup are registered.
REQ-029 The state register never holds all-zero.

Reset
REQ-030 On rst=1 at a clock edge: state_out = SEED, FSM = IDLE, count = 0, busy = 0, done = 0, lockup = 0.
REQ-031 rst has priority over load, start, and enable; mid-burst reset aborts with no done pulse.

Structure
REQ-032 Shared package lfsr_pkg holds the FSM state enum, the mode constants MODE_FIB/MODE_GAL, and the default maximal-tap constants for widths 4, 8, 16, and 32.
REQ-033 One combinational sub-module, lfsr_next (WIDTH, TAPS, MODE; state in, next state out), is instantiated once.

Verification
REQ-034 WIDTH=4, TAPS=4'b1001, MODE=0, SEED=1: reset, then enable for 1 cycle -> state 0011; continue to 15 total steps -> state 0001; all 15 nonzero values visited exactly once.
REQ-035 WIDTH=4, TAPS=4'b1100, MODE=1, SEED=1: enable 3 cycles -> 1100, 0110, 0011; period = 15.
REQ-036 Burst: start with n_steps=5 -> busy high for exactly 5 cycles, 5 steps taken, done pulses 1 cycle after the last step, busy=0 during the done cycle.
REQ-037 start with n_steps=0 -> no state change, done pulses once on the following cycle, busy never rises.
REQ-038 load with seed_in=0 -> state = SEED, lockup pulses 1 cycle; load of 1010 during RUN -> state 1010, the burst still ends on the original cycle.
REQ-039 rst asserted on the 3rd cycle of a 10-step burst -> next cycle state = SEED, busy = 0, no done pulse.
